regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised integer register file for the RISC-V core with N combinational read ports, one synchronous write port, optional write-to-read bypass, and a per-register busy scoreboard. Decode uses it to read operands and detect RAW hazards. Issue marks destination registers pending, and writeback both commits data and clears the pending bit. It replaces the fixed 2-read, 32x32 register file and keeps x0 hardwired to zero.

## Interface
Parameters:
- XLEN, 32, data width
- NREGS, 32, register count (power of two, >= 2); AW = $clog2(NREGS)
- NREAD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- write_enable  in  1  commit write_data_in to write_addr this edge
- write_addr  in  AW  destination register
- write_data_in  in  XLEN  writeback data
- issue_valid  in  1  an instruction with destination issue_rd issues this cycle
- issue_rd  in  AW  destination register to mark busy
- read_en  in  NREAD  per-port operand-used flag (hazard qualification only)
- read_addr  in  NREAD*AW  packed read addresses, port i at [i*AW +: AW]
- read_data_out  out  NREAD*XLEN  packed read data, port i at [i*XLEN +: XLEN]
- read_busy  out  NREAD  port i operand still pending
- stall  out  1  OR over i of (read_en[i] & read_busy[i])
- busy_vec  out  NREGS  current scoreboard, bit 0 always 0

## Operation
- Storage: NREGS-1 registers of XLEN bits. Register 0 has no storage, reads 0, and is never busy.
- Reset (reset=0, asynchronous): all registers become 0 and busy_vec becomes 0. The outputs read_data_out, read_busy and stall then all read 0 for any address.
- Write: on the rising edge, if reset=1, write_enable=1 and write_addr!=0, then regs[write_addr] <= write_data_in. A write to address 0 is silently dropped.
- Read port i (combinational):
  - addr 0 -> 0.
  - Otherwise, if BYPASS=1, write_enable=1 and write_addr==addr -> write_data_in.
  - Otherwise -> regs[addr].
  - The same address on several ports is legal; each port returns identical data.
- Scoreboard, evaluated per rising edge for each register r != 0:
  - set if issue_valid=1 and issue_rd==r
  - clear if write_enable=1 and write_addr==r
  - set and clear on the same r in the same cycle -> busy stays/becomes 1. The new producer wins.
  - issue_rd==0 has no effect.
- read_busy[i] = busy_vec[addr_i], with one exception: it is 0 when BYPASS=1, write_enable=1 and write_addr==addr_i, because the forwarded value resolves the hazard. When BYPASS=0, read_busy stays 1 through the writeback cycle.
- read_busy is independent of read_en. read_en only gates stall.
- A write to a non-busy register is legal: data is committed and the scoreboard is unchanged.

## Timing
- Read latency: 0 cycles (combinational from read_addr, write inputs and state).
- Write visible at the outputs:
  - BYPASS=1: in the same cycle.
  - BYPASS=0: from the cycle after the edge.
- Issue-to-busy latency: 1 edge. busy_vec and read_busy rise after the edge that samples issue_valid.
- Writeback-to-not-busy:
  - Same cycle via the bypass qualification when BYPASS=1.
  - busy_vec bit clears after the edge.
- Reset assertion mid-operation immediately clears all state, regardless of clk. A write or issue presented on the edge coincident with reset=0 is discarded.
- Deassertion is synchronised externally. The first state update is the first rising edge with reset=1.

## Test plan
- Reset then sweep: pulse reset low, read all NREGS addresses on every port -> all 0; busy_vec=0, stall=0.
- Write/readback including x0: write 4000000->x2, 26794->x7, 588890->x25, 4096->x0, then sweep -> x2/x7/x25 hold the written values, x0 and all others read 0.
- Bypass: BYPASS=1, x5=0, present write_enable=1, addr 5, data 0xDEADBEEF with read_addr0=5 -> read_data_out0=0xDEADBEEF in the same cycle. With BYPASS=0 -> 0 that cycle, 0xDEADBEEF the next.
- Scoreboard hazard: issue x9, next cycle read_en0=1, read_addr0=9 -> read_busy0=1, stall=1. Write x9 -> with BYPASS=1, stall=0 in that cycle and busy_vec[9]=0 after the edge.
- Simultaneous set/clear: issue_rd=12 and write_addr=12 on the same edge -> busy_vec[12]=1 afterwards and regs[12] updated. issue_rd=0 -> busy_vec[0] stays 0.
- Reset mid-operation: with x3=7 and busy_vec[4]=1, drop reset low between clock edges -> read of x3 is 0 and busy_vec=0 immediately, before the next edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with N combinational read ports, one write port, optional
// write-to-read forwarding and a per-register busy scoreboard for RAW hazard detection.
module regfile_scoreboard #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [AW-1:0]         write_addr,
    input  logic [XLEN-1:0]       write_data_in,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    input  logic [NREAD-1:0]      read_en,
    input  logic [NREAD*AW-1:0]   read_addr,
    output logic [NREAD*XLEN-1:0] read_data_out,
    output logic [NREAD-1:0]      read_busy,
    output logic                  stall,
    output logic [NREGS-1:0]      busy_vec
);

    logic [XLEN-1:0]  regs [1:NREGS-1];
    logic [NREGS-1:1] busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 1; r < NREGS; r++) regs[r] <= '0;
            busy_q <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (write_enable && write_addr == AW'(r)) regs[r] <= write_data_in;
                // a new producer issued on the writeback edge keeps the register busy
                if (issue_valid && issue_rd == AW'(r))
                    busy_q[r] <= 1'b1;
                else if (write_enable && write_addr == AW'(r))
                    busy_q[r] <= 1'b0;
            end
        end
    end

    assign busy_vec = {busy_q, 1'b0};

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit;
        logic [XLEN-1:0] stored;

        assign addr = read_addr[i*AW +: AW];
        assign hit  = (BYPASS != 0) && write_enable && (write_addr == addr);

        always_comb begin
            stored = '0;
            for (int r = 1; r < NREGS; r++)
                if (addr == AW'(r)) stored = regs[r];
        end

        assign read_data_out[i*XLEN +: XLEN] = (addr == '0) ? '0 :
                                               hit          ? write_data_in : stored;
        // forwarded data resolves the hazard in the writeback cycle
        assign read_busy[i] = busy_vec[addr] & ~hit;
    end

    assign stall = |(read_en & read_busy);

endmodule
